// File: rtl/saturn_def_field.sv
// Shared definitions for the Saturn operand field collector: mode codes and FSM state encoding.
package saturn_def_field;

    localparam logic [1:0] FIELD_MODE_RAW  = 2'd0;
    localparam logic [1:0] FIELD_MODE_REL  = 2'd1;
    localparam logic [1:0] FIELD_MODE_ABS  = 2'd2;
    localparam logic [1:0] FIELD_MODE_RSVD = 2'd3;

    typedef enum logic [1:0] {
        FIELD_ST_IDLE    = 2'd0,
        FIELD_ST_COLLECT = 2'd1,
        FIELD_ST_DONE    = 2'd2
    } field_state_t;

endpackage

// File: rtl/saturn_field_sext_add.sv
// Sign-extends a variable-length nibble field from its top collected nibble and adds it
// to a base address, wrapping modulo 2^ADDR_WIDTH.
module saturn_field_sext_add #(
    parameter int MAX_NIBBLES = 5,
    parameter int ADDR_WIDTH  = 20
) (
    input  logic [4*MAX_NIBBLES-1:0] field,
    input  logic [2:0]               length,
    input  logic [ADDR_WIDTH-1:0]    base,
    output logic [ADDR_WIDTH-1:0]    target
);

    localparam int FIELD_W = 4 * MAX_NIBBLES;
    localparam int EXT_W   = (FIELD_W > ADDR_WIDTH) ? FIELD_W : ADDR_WIDTH;

    logic             sign;
    logic [EXT_W-1:0] ext;

    always_comb begin
        sign = 1'b0;
        for (int i = 0; i < MAX_NIBBLES; i++) begin
            if (int'(length) == i + 1) begin
                sign = field[4*i+3];
            end
        end
        // Slots at or above length are filled with the sign, not with whatever sits in the field.
        ext = {EXT_W{sign}};
        for (int i = 0; i < MAX_NIBBLES; i++) begin
            if (i < int'(length)) begin
                ext[4*i +: 4] = field[4*i +: 4];
            end
        end
        target = ext[ADDR_WIDTH-1:0] + base;
    end

endmodule

// File: rtl/saturn_field_collector.sv
// Multi-nibble operand collector (raw / PC-relative / absolute) fed by the decoder nibble stream.
// Optional SATURN_FIELD_RTN_DETECT_EN adds an all-zero relative field flag.
module saturn_field_collector
    import saturn_def_field::*;
#(
    parameter int MAX_NIBBLES = 5,
    parameter int ADDR_WIDTH  = 20
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clk_en,
    input  logic [3:0]               i_phases,
    input  logic                     i_bus_busy,
    input  logic                     i_start,
    input  logic [2:0]               i_length,
    input  logic [1:0]               i_mode,
    input  logic [ADDR_WIDTH-1:0]    i_base_pc,
    input  logic [3:0]               i_nibble,
    output logic                     o_busy,
    output logic [2:0]               o_count,
    output logic [4*MAX_NIBBLES-1:0] o_field,
    output logic [ADDR_WIDTH-1:0]    o_target,
    output logic                     o_valid,
    output logic                     o_field_zero,
    output logic                     o_error
);

    localparam int FIELD_W = 4 * MAX_NIBBLES;

    field_state_t          state_q, state_d;
    logic [2:0]            count_q, count_d;
    logic [2:0]            len_q, len_d;
    logic [1:0]            mode_q, mode_d;
    logic [FIELD_W-1:0]    field_q, field_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;

    logic                  qualify;
    logic                  capture;
    logic                  complete;
    logic                  cleanup;
    logic                  request_ok;
    logic [FIELD_W-1:0]    captured_field;
    logic [ADDR_WIDTH-1:0] rel_target;
    logic                  unused_phases;

    assign unused_phases = ^i_phases[1:0];
    assign qualify       = i_clk_en & ~i_bus_busy;

    // The final nibble is folded in combinationally so the target is ready on the capture edge.
    always_comb begin
        captured_field = field_q;
        for (int i = 0; i < MAX_NIBBLES; i++) begin
            if (int'(count_q) == i) begin
                captured_field[4*i +: 4] = i_nibble;
            end
        end
        capture    = qualify && (state_q == FIELD_ST_COLLECT) && i_phases[2];
        complete   = capture && ((count_q + 3'd1) == len_q);
        cleanup    = qualify && (state_q == FIELD_ST_DONE) && i_phases[3];
        request_ok = (i_length != 3'd0) && (int'(i_length) <= MAX_NIBBLES)
                     && (i_mode != FIELD_MODE_RSVD);
    end

    saturn_field_sext_add #(
        .MAX_NIBBLES (MAX_NIBBLES),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_sext_add (
        .field  (captured_field),
        .length (len_q),
        .base   (base_q),
        .target (rel_target)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        len_d    = len_q;
        mode_d   = mode_q;
        field_d  = field_q;
        base_d   = base_q;
        target_d = target_q;
        valid_d  = valid_q;
        error_d  = error_q;
        case (state_q)
            FIELD_ST_IDLE: begin
                if (qualify && i_start) begin
                    if (request_ok) begin
                        len_d    = i_length;
                        mode_d   = i_mode;
                        base_d   = i_base_pc;
                        field_d  = '0;
                        count_d  = '0;
                        target_d = '0;
                        state_d  = FIELD_ST_COLLECT;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            FIELD_ST_COLLECT: begin
                if (capture) begin
                    field_d = captured_field;
                    count_d = count_q + 3'd1;
                    if (complete) begin
                        state_d = FIELD_ST_DONE;
                        valid_d = 1'b1;
                        case (mode_q)
                            FIELD_MODE_ABS: target_d = ADDR_WIDTH'(captured_field);
                            FIELD_MODE_REL: target_d = rel_target;
                            default:        target_d = '0;
                        endcase
                    end
                end
            end
            FIELD_ST_DONE: begin
                if (cleanup) begin
                    valid_d = 1'b0;
                    state_d = FIELD_ST_IDLE;
                end
            end
            default: state_d = FIELD_ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= FIELD_ST_IDLE;
            count_q  <= '0;
            len_q    <= '0;
            mode_q   <= FIELD_MODE_RAW;
            field_q  <= '0;
            base_q   <= '0;
            target_q <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            len_q    <= len_d;
            mode_q   <= mode_d;
            field_q  <= field_d;
            base_q   <= base_d;
            target_q <= target_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

`ifdef SATURN_FIELD_RTN_DETECT_EN
    // Unused slots are cleared at start, so a whole-field compare covers only collected nibbles.
    logic field_zero_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            field_zero_q <= 1'b0;
        end else if (complete) begin
            field_zero_q <= (mode_q == FIELD_MODE_REL) && (captured_field == '0);
        end else if (cleanup) begin
            field_zero_q <= 1'b0;
        end
    end

    assign o_field_zero = field_zero_q;
`else
    assign o_field_zero = 1'b0;
`endif

    assign o_busy   = (state_q == FIELD_ST_COLLECT);
    assign o_count  = count_q;
    assign o_field  = field_q;
    assign o_target = target_q;
    assign o_valid  = valid_q;
    assign o_error  = error_q;

endmodule

// File: tb/tb_saturn_field_collector.sv
// Directed testbench for saturn_field_collector; expected values are hand-computed per vector.
module tb_saturn_field_collector;

    localparam logic [1:0] M_RAW = 2'd0;
    localparam logic [1:0] M_REL = 2'd1;
    localparam logic [1:0] M_ABS = 2'd2;
    localparam logic [1:0] M_RSV = 2'd3;

`ifdef SATURN_FIELD_RTN_DETECT_EN
    localparam logic RTN_EN = 1'b1;
`else
    localparam logic RTN_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_clk_en;
    logic [3:0]  i_phases;
    logic        i_bus_busy;
    logic        i_start;
    logic [2:0]  i_length;
    logic [1:0]  i_mode;
    logic [19:0] i_base_pc;
    logic [3:0]  i_nibble;
    logic        o_busy;
    logic [2:0]  o_count;
    logic [19:0] o_field;
    logic [19:0] o_target;
    logic        o_valid;
    logic        o_field_zero;
    logic        o_error;

    int checks   = 0;
    int failures = 0;

    saturn_field_collector #(
        .MAX_NIBBLES (5),
        .ADDR_WIDTH  (20)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clk_en     (i_clk_en),
        .i_phases     (i_phases),
        .i_bus_busy   (i_bus_busy),
        .i_start      (i_start),
        .i_length     (i_length),
        .i_mode       (i_mode),
        .i_base_pc    (i_base_pc),
        .i_nibble     (i_nibble),
        .o_busy       (o_busy),
        .o_count      (o_count),
        .o_field      (o_field),
        .o_target     (o_target),
        .o_valid      (o_valid),
        .o_field_zero (o_field_zero),
        .o_error      (o_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of stimulus and returns 1ns after the sampling edge.
    task automatic applyStimulus(input logic start, input logic [3:0] phases,
                                 input logic [3:0] nibble, input logic busy);
        i_start    = start;
        i_phases   = phases;
        i_nibble   = nibble;
        i_bus_busy = busy;
        @(posedge i_clk);
        #1;
        i_start  = 1'b0;
        i_phases = 4'b0000;
    endtask

    task automatic doReset();
        i_reset = 1'b1;
        applyStimulus(1'b0, 4'b0100, 4'hC, 1'b0);
        i_reset = 1'b0;
    endtask

    task automatic collect(input logic [2:0] len, input logic [1:0] mode,
                           input logic [19:0] base, input logic [19:0] nibs);
        i_length  = len;
        i_mode    = mode;
        i_base_pc = base;
        applyStimulus(1'b1, 4'b0000, 4'h0, 1'b0);
        for (int i = 0; i < int'(len); i++) begin
            applyStimulus(1'b0, 4'b0100, nibs[4*i +: 4], 1'b0);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"},  32'(o_busy), 32'd0);
        checkOutput({tag, "_count"}, 32'(o_count), 32'd0);
        checkOutput({tag, "_field"}, 32'(o_field), 32'd0);
        checkOutput({tag, "_target"}, 32'(o_target), 32'd0);
        checkOutput({tag, "_valid"}, 32'(o_valid), 32'd0);
        checkOutput({tag, "_fzero"}, 32'(o_field_zero), 32'd0);
        checkOutput({tag, "_error"}, 32'(o_error), 32'd0);
    endtask

    initial begin
        i_reset    = 1'b0;
        i_clk_en   = 1'b1;
        i_phases   = 4'b0000;
        i_bus_busy = 1'b0;
        i_start    = 1'b0;
        i_length   = 3'd0;
        i_mode     = M_RAW;
        i_base_pc  = 20'h0;
        i_nibble   = 4'h0;
        doReset();
        checkResetState("reset");

        // Relative, -13 + 0x100 = 0xF3.
        collect(3'd2, M_REL, 20'h00100, 20'h000F3);
        checkOutput("rel_field",  32'(o_field), 32'h000F3);
        checkOutput("rel_target", 32'(o_target), 32'h000F3);
        checkOutput("rel_valid",  32'(o_valid), 32'd1);
        checkOutput("rel_count",  32'(o_count), 32'd2);
        checkOutput("rel_busy",   32'(o_busy), 32'd0);
        checkOutput("rel_fzero",  32'(o_field_zero), 32'd0);
        applyStimulus(1'b0, 4'b0000, 4'h0, 1'b0);
        checkOutput("rel_valid_hold", 32'(o_valid), 32'd1);
        applyStimulus(1'b0, 4'b1000, 4'h0, 1'b0);
        checkOutput("rel_valid_clr",    32'(o_valid), 32'd0);
        checkOutput("rel_field_hold",   32'(o_field), 32'h000F3);
        checkOutput("rel_target_hold",  32'(o_target), 32'h000F3);

        // Absolute, 5 nibbles; the nibble on the start cycle must be ignored.
        i_length  = 3'd5;
        i_mode    = M_ABS;
        i_base_pc = 20'h0;
        applyStimulus(1'b1, 4'b0100, 4'h9, 1'b0);
        checkOutput("abs_start_count", 32'(o_count), 32'd0);
        checkOutput("abs_start_busy",  32'(o_busy), 32'd1);
        for (int n = 1; n <= 5; n++) begin
            applyStimulus(1'b0, 4'b0100, 4'(n), 1'b0);
        end
        checkOutput("abs_field",  32'(o_field), 32'h54321);
        checkOutput("abs_target", 32'(o_target), 32'h54321);
        checkOutput("abs_count",  32'(o_count), 32'd5);
        checkOutput("abs_valid",  32'(o_valid), 32'd1);
        applyStimulus(1'b1, 4'b1000, 4'h0, 1'b0);
        checkOutput("abs_clr_valid", 32'(o_valid), 32'd0);
        checkOutput("abs_clr_busy",  32'(o_busy), 32'd0);
        applyStimulus(1'b0, 4'b0000, 4'h0, 1'b0);
        checkOutput("abs_start_ignored", 32'(o_busy), 32'd0);

        // Relative wrap: 0xFFFF0 + 0x20 = 0x00010.
        collect(3'd2, M_REL, 20'hFFFF0, 20'h00020);
        checkOutput("wrap_target", 32'(o_target), 32'h00010);
        applyStimulus(1'b0, 4'b1000, 4'h0, 1'b0);

        // Stall and clock-enable freeze mid-field, then stalled cleanup.
        i_length  = 3'd2;
        i_mode    = M_REL;
        i_base_pc = 20'h00100;
        applyStimulus(1'b1, 4'b0000, 4'h0, 1'b0);
        applyStimulus(1'b0, 4'b0100, 4'h3, 1'b0);
        checkOutput("stall_count1", 32'(o_count), 32'd1);
        applyStimulus(1'b0, 4'b0100, 4'h7, 1'b1);
        applyStimulus(1'b0, 4'b0100, 4'h7, 1'b1);
        checkOutput("stall_count_frozen", 32'(o_count), 32'd1);
        i_clk_en = 1'b0;
        applyStimulus(1'b0, 4'b0100, 4'h7, 1'b0);
        i_clk_en = 1'b1;
        checkOutput("clken_count_frozen", 32'(o_count), 32'd1);
        applyStimulus(1'b0, 4'b0100, 4'hF, 1'b0);
        checkOutput("stall_field",  32'(o_field), 32'h000F3);
        checkOutput("stall_target", 32'(o_target), 32'h000F3);
        checkOutput("stall_valid",  32'(o_valid), 32'd1);
        applyStimulus(1'b0, 4'b1000, 4'h0, 1'b1);
        checkOutput("stall_cleanup_held", 32'(o_valid), 32'd1);
        applyStimulus(1'b0, 4'b1000, 4'h0, 1'b0);
        checkOutput("stall_cleanup_done", 32'(o_valid), 32'd0);

        // All-zero relative field.
        collect(3'd2, M_REL, 20'h12345, 20'h00000);
        checkOutput("zero_target", 32'(o_target), 32'h12345);
        checkOutput("zero_valid",  32'(o_valid), 32'd1);
        checkOutput("zero_flag",   32'(o_field_zero), 32'(RTN_EN));
        applyStimulus(1'b0, 4'b1000, 4'h0, 1'b0);
        checkOutput("zero_flag_clr", 32'(o_field_zero), 32'd0);
        checkOutput("no_error_yet",  32'(o_error), 32'd0);

        // Bad requests.
        i_length = 3'd0;
        i_mode   = M_REL;
        applyStimulus(1'b1, 4'b0000, 4'h0, 1'b0);
        checkOutput("len0_error", 32'(o_error), 32'd1);
        checkOutput("len0_busy",  32'(o_busy), 32'd0);
        doReset();
        checkOutput("err_reset", 32'(o_error), 32'd0);
        i_length = 3'd2;
        i_mode   = M_RSV;
        applyStimulus(1'b1, 4'b0000, 4'h0, 1'b0);
        checkOutput("mode3_error", 32'(o_error), 32'd1);
        checkOutput("mode3_busy",  32'(o_busy), 32'd0);
        doReset();
        i_length = 3'd6;
        i_mode   = M_ABS;
        applyStimulus(1'b1, 4'b0000, 4'h0, 1'b0);
        checkOutput("len6_error", 32'(o_error), 32'd1);
        doReset();

        // Reset after 2 of 4 nibbles.
        i_length  = 3'd4;
        i_mode    = M_REL;
        i_base_pc = 20'h00000;
        applyStimulus(1'b1, 4'b0000, 4'h0, 1'b0);
        applyStimulus(1'b0, 4'b0100, 4'hA, 1'b0);
        applyStimulus(1'b0, 4'b0100, 4'hB, 1'b0);
        checkOutput("mid_count", 32'(o_count), 32'd2);
        checkOutput("mid_field", 32'(o_field), 32'h000BA);
        doReset();
        checkResetState("midreset");
        applyStimulus(1'b0, 4'b0100, 4'hD, 1'b0);
        checkOutput("midreset_idle_count", 32'(o_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
